// File: rtl/ibex_cheri_mem_exc_queue.sv
// ibex_cheri_mem_exc_queue
// In-order tracker that captures the CHERI checker's exception vector at each
// granted request and replays it alongside the matching response. It throttles
// new requests while full and flags responses that arrive with nothing outstanding.
// Optional feature: define IBEX_CHERI_EXC_RDATA_SUPPRESS_EN to zero response
// data whenever the completing transaction carries an exception.
module ibex_cheri_mem_exc_queue #(
  parameter int unsigned Depth         = 2,
  parameter logic        DataMem       = 1'b1,
  parameter int unsigned CheriExcWidth = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       data_req_i,
  output logic                       data_req_o,
  input  logic                       data_gnt_i,
  output logic                       data_gnt_o,
  input  logic                       data_rvalid_i,
  input  logic [31:0]                data_rdata_i,
  output logic [31:0]                data_rdata_o,
  input  logic [CheriExcWidth-1:0]   cheri_exc_i,
  input  logic                       instr_upper_exc_i,
  output logic [CheriExcWidth-1:0]   cheri_exc_o,
  output logic                       instr_upper_exc_o,
  output logic [$clog2(Depth+1)-1:0] outstanding_o,
  output logic                       full_o,
  output logic                       spurious_rvalid_o
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned EntW = CheriExcWidth + 1;

  logic [EntW-1:0] entries_q [Depth];
  logic [PtrW-1:0] wptr_q;
  logic [PtrW-1:0] rptr_q;
  logic [CntW-1:0] count_q;

  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [EntW-1:0] head;
  logic [EntW-1:0] wr_entry;

  assign full     = (count_q == CntW'(Depth));
  assign empty    = (count_q == '0);
  assign push     = data_req_i & data_gnt_i & ~full;
  assign pop      = data_rvalid_i & ~empty;
  assign head     = entries_q[rptr_q];
  assign wr_entry = {(DataMem ? 1'b0 : instr_upper_exc_i), cheri_exc_i};

  // Entry storage: written at the write pointer on every accepted grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        entries_q[i] <= '0;
      end
    end else if (push) begin
      entries_q[wptr_q] <= wr_entry;
    end
  end

  // Pointers wrap at Depth-1 by compare so non-power-of-two depths work.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) begin
        wptr_q <= (wptr_q == PtrW'(Depth - 1)) ? '0 : wptr_q + PtrW'(1);
      end
      if (pop) begin
        rptr_q <= (rptr_q == PtrW'(Depth - 1)) ? '0 : rptr_q + PtrW'(1);
      end
    end
  end

  // Occupancy: a push and pop in the same cycle cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Response-side outputs: head entry is presented only on the popping cycle.
  always_comb begin
    cheri_exc_o       = '0;
    instr_upper_exc_o = 1'b0;
    data_rdata_o      = data_rdata_i;
    if (pop) begin
      cheri_exc_o       = head[CheriExcWidth-1:0];
      instr_upper_exc_o = head[CheriExcWidth];
`ifdef IBEX_CHERI_EXC_RDATA_SUPPRESS_EN
      if (head != '0) begin
        data_rdata_o = '0;
      end
`endif
    end
  end

  // Gating uses only registered fullness, so rvalid never reaches req combinationally.
  assign data_req_o        = data_req_i & ~full;
  assign data_gnt_o        = data_gnt_i & ~full;
  assign full_o            = full;
  assign outstanding_o     = count_q;
  assign spurious_rvalid_o = rst_ni & data_rvalid_i & empty;

endmodule
